// File: rtl/icache_nway.sv
// icache_nway: parametrised set-associative instruction cache.
// Cached fetches are looked up through per-way synchronous tag/data arrays
// (one request per cycle on hits). A miss refills one whole line from the
// read bridge. Uncached fetches pass through as single-word reads. Whole sets
// can be invalidated, and hit/miss counters are kept.

module icache_nway_chk #(
  parameter int WAYS = 2
) (
  input logic            clk,
  input logic            reset,
  input logic            lookup,
  input logic [WAYS-1:0] way_hit
);
  // A tag may live in at most one way of a set, so a lookup may match at most one way
  always @(posedge clk) begin
    if (!reset && lookup) begin
      assert ($onehot0(way_hit))
        else $error("icache_nway: %0d ways hit in a single lookup", $countones(way_hit));
    end
  end
endmodule

module icache_nway #(
  parameter int WAYS     = 2,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid,
  input  logic                          uncache,
  input  logic [31-INDEX_W-OFFSET_W:0]  tag,
  input  logic [INDEX_W-1:0]            index,
  input  logic [OFFSET_W-1:0]           offset,
  output logic                          addr_ok,
  output logic                          data_ok,
  output logic [8*(2**OFFSET_W)-1:0]    rdata,
  output logic [OFFSET_W-2:0]           rnum,
  input  logic                          inv_valid,
  input  logic [INDEX_W-1:0]            inv_index,
  output logic                          inv_ok,
  output logic                          rd_req,
  output logic                          rd_type,
  output logic [31:0]                   rd_addr,
  input  logic                          rd_rdy,
  input  logic                          ret_valid,
  input  logic [8*(2**OFFSET_W)-1:0]    ret_data,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt
);
  localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
  localparam int SETS   = 2 ** INDEX_W;
  localparam int LINE_W = 8 * (2 ** OFFSET_W);
  localparam int WORDS  = 2 ** (OFFSET_W - 2);
  localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_REFILL = 3'd3,
    S_UREQ   = 3'd4,
    S_URESP  = 3'd5
  } state_t;

  state_t              state_r;
  logic [TAG_W-1:0]    rb_tag_r;
  logic [INDEX_W-1:0]  rb_index_r;
  logic [OFFSET_W-1:0] rb_offset_r;
  logic [WAYS-1:0]     valid_r [SETS];
  logic [RR_W-1:0]     rr_r [SETS];
  logic [RR_W-1:0]     victim_r;
  logic                victim_rr_r;
  logic [31:0]         hit_cnt_r;
  logic [31:0]         miss_cnt_r;

  logic [TAG_W-1:0]    tag_dout_s [WAYS];
  logic [LINE_W-1:0]   data_dout_s [WAYS];
  logic [WAYS-1:0]     way_hit_s;
  logic [RR_W-1:0]     hit_way_s;
  logic                hit_s;
  logic [RR_W-1:0]     victim_s;
  logic                victim_rr_s;
  logic                found_s;
  logic                accept_s;
  logic                array_rd_s;
  logic                refill_wr_s;
  logic [OFFSET_W-2:0] rnum_line_s;

  assign accept_s    = valid && !inv_valid && ((state_r == S_IDLE) || hit_s);
  assign array_rd_s  = accept_s && !uncache;
  assign refill_wr_s = (state_r == S_REFILL) && ret_valid && !reset;
  assign rnum_line_s = (OFFSET_W-1)'(WORDS) - {1'b0, rb_offset_r[OFFSET_W-1:2]};
  assign addr_ok     = accept_s;
  assign inv_ok      = (state_r == S_IDLE) && inv_valid;
  assign hit_cnt     = hit_cnt_r;
  assign miss_cnt    = miss_cnt_r;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W-1:0]  tag_ram_r  [SETS];
    logic [LINE_W-1:0] data_ram_r [SETS];
    logic [TAG_W-1:0]  tag_rd_r;
    logic [LINE_W-1:0] data_rd_r;

    // Way storage: refill writes the victim way, accepted cached requests read all ways
    always_ff @(posedge clk) begin
      if (refill_wr_s && (victim_r == RR_W'(w))) begin
        tag_ram_r[rb_index_r]  <= rb_tag_r;
        data_ram_r[rb_index_r] <= ret_data;
      end
      if (array_rd_s) begin
        tag_rd_r  <= tag_ram_r[index];
        data_rd_r <= data_ram_r[index];
      end
    end

    assign tag_dout_s[w]  = tag_rd_r;
    assign data_dout_s[w] = data_rd_r;
  end

  // Tag compare across all ways of the buffered set
  always_comb begin
    way_hit_s = '0;
    hit_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_r[rb_index_r][w] && (tag_dout_s[w] == rb_tag_r)) begin
        way_hit_s[w] = 1'b1;
        hit_way_s    = RR_W'(w);
      end else begin
        way_hit_s[w] = 1'b0;
      end
    end
    hit_s = (state_r == S_LOOKUP) && (|way_hit_s);
  end

  // Victim: lowest-numbered invalid way, otherwise the set's round-robin pointer
  always_comb begin
    victim_s    = rr_r[rb_index_r];
    victim_rr_s = 1'b1;
    found_s     = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_s && !valid_r[rb_index_r][w]) begin
        victim_s    = RR_W'(w);
        victim_rr_s = 1'b0;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Response to fetch: hit line, refilled line, or uncached word at the MSB end
  always_comb begin
    data_ok = 1'b0;
    rdata   = '0;
    rnum    = '0;
    case (state_r)
      S_LOOKUP: begin
        data_ok = hit_s;
        rdata   = hit_s ? data_dout_s[hit_way_s] : '0;
        rnum    = hit_s ? rnum_line_s : '0;
      end
      S_REFILL: begin
        data_ok = ret_valid;
        rdata   = ret_valid ? ret_data : '0;
        rnum    = ret_valid ? rnum_line_s : '0;
      end
      S_URESP: begin
        data_ok = ret_valid;
        rdata   = ret_valid ? {ret_data[31:0], {(LINE_W-32){1'b0}}} : '0;
        rnum    = ret_valid ? (OFFSET_W-1)'(1) : '0;
      end
      default: begin
        data_ok = 1'b0;
        rdata   = '0;
        rnum    = '0;
      end
    endcase
  end

  // Bridge read request: full line while missing, single word while uncached
  always_comb begin
    rd_req  = 1'b0;
    rd_type = 1'b0;
    rd_addr = 32'h0000_0000;
    case (state_r)
      S_MISS: begin
        rd_req  = 1'b1;
        rd_type = 1'b1;
        rd_addr = {rb_tag_r, rb_index_r, {OFFSET_W{1'b0}}};
      end
      S_UREQ: begin
        rd_req  = 1'b1;
        rd_type = 1'b0;
        rd_addr = {rb_tag_r, rb_index_r, rb_offset_r};
      end
      default: begin
        rd_req  = 1'b0;
        rd_type = 1'b0;
        rd_addr = 32'h0000_0000;
      end
    endcase
  end

  // Control FSM with request buffer, valid bits, victim pointers and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      rb_tag_r    <= '0;
      rb_index_r  <= '0;
      rb_offset_r <= '0;
      victim_r    <= '0;
      victim_rr_r <= 1'b0;
      hit_cnt_r   <= 32'd0;
      miss_cnt_r  <= 32'd0;
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        rr_r[s]    <= '0;
      end
    end else begin
      if (accept_s) begin
        rb_tag_r    <= tag;
        rb_index_r  <= index;
        rb_offset_r <= offset;
      end
      case (state_r)
        S_IDLE: begin
          if (inv_valid) begin
            valid_r[inv_index] <= '0;
            rr_r[inv_index]    <= '0;
          end else if (accept_s) begin
            state_r <= uncache ? S_UREQ : S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_s) begin
            hit_cnt_r <= hit_cnt_r + 32'd1;
            if (accept_s) begin
              state_r <= uncache ? S_UREQ : S_LOOKUP;
            end else begin
              state_r <= S_IDLE;
            end
          end else begin
            miss_cnt_r  <= miss_cnt_r + 32'd1;
            victim_r    <= victim_s;
            victim_rr_r <= victim_rr_s;
            state_r     <= S_MISS;
          end
        end
        S_MISS: begin
          if (rd_rdy) state_r <= S_REFILL;
        end
        S_REFILL: begin
          if (ret_valid) begin
            valid_r[rb_index_r][victim_r] <= 1'b1;
            if (victim_rr_r) begin
              rr_r[rb_index_r] <= (rr_r[rb_index_r] == RR_W'(WAYS - 1)) ? '0
                                  : rr_r[rb_index_r] + RR_W'(1);
            end
            state_r <= S_IDLE;
          end
        end
        S_UREQ: begin
          if (rd_rdy) state_r <= S_URESP;
        end
        S_URESP: begin
          if (ret_valid) state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  icache_nway_chk #(.WAYS(WAYS)) u_chk (
    .clk     (clk),
    .reset   (reset),
    .lookup  (state_r == S_LOOKUP),
    .way_hit (way_hit_s)
  );

endmodule
